// File: rtl/adder_stim_pkg.sv
// Shared types and constants for the adder stimulus/checker.
package adder_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_LATENCY = 1;

  // Right-shifting Galois feedback masks giving a maximal-length sequence.
  function automatic logic [63:0] lfsr_taps(input int n);
    logic [63:0] taps;
    case (n)
      8:       taps = 64'h0000_0000_0000_00B8;
      12:      taps = 64'h0000_0000_0000_0E08;
      16:      taps = 64'h0000_0000_0000_B400;
      20:      taps = 64'h0000_0000_0009_0000;
      24:      taps = 64'h0000_0000_00E1_0000;
      32:      taps = 64'h0000_0000_8020_0003;
      default: taps = 64'h0000_0000_0000_B400;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/adder_stim_chk_lfsr.sv
// Seedable Galois LFSR; load takes priority over advance.
module stim_lfsr
  import adder_stim_pkg::*;
#(
  parameter int           N    = 16,
  parameter logic [N-1:0] TAPS = N'(16'hB400)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         advance,
  input  logic [N-1:0] seed,
  output logic [N-1:0] state
);

  // An all-zero register never leaves zero, so a zero seed becomes 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= N'(1);
    end else if (load) begin
      state <= (seed == '0) ? N'(1) : seed;
    end else if (advance) begin
      state <= (state >> 1) ^ (state[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/adder_stim_chk.sv
// Pseudo-random operand source and result checker for the adder interface.
// State table:
//   IDLE  | waiting for start
//   RUN   | issuing one operand pair per cycle
//   DRAIN | waiting LATENCY cycles for the last results to be checked
//   DONE  | one-cycle done pulse, pass valid
module adder_stim_chk
  import adder_stim_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_vec,
  input  logic [2*WIDTH-1:0] seed,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [WIDTH:0]     c,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   vec_cnt
);

  localparam int                LFSR_W = 2 * WIDTH;
  localparam logic [LFSR_W-1:0] TAPS   = LFSR_W'(lfsr_taps(LFSR_W));

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   num_vec_q;
  logic [3:0]         drain_cnt;
  logic [LFSR_W-1:0]  lfsr_q;
  logic               accept;
  logic               issue;
  logic               mismatch;
  logic [CNT_W-1:0]   err_nxt;
  logic [WIDTH:0]     exp_new;
  logic               pipe_vld [LATENCY];
  logic [WIDTH:0]     pipe_exp [LATENCY];

  assign accept  = (state == IDLE) && start;
  assign issue   = (state == RUN);
  assign exp_new = {1'b0, lfsr_q[WIDTH-1:0]} + {1'b0, lfsr_q[LFSR_W-1:WIDTH]};
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);

  stim_lfsr #(
    .N    (LFSR_W),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .advance (issue),
    .seed    (seed),
    .state   (lfsr_q)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if ((vec_cnt + CNT_W'(1)) == num_vec_q) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == 4'd0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result compare at the end of the expectation pipeline, with saturating error count.
  always_comb begin
    mismatch = pipe_vld[LATENCY-1] && (c != pipe_exp[LATENCY-1]);
    err_nxt  = err_cnt;
    if (accept) begin
      err_nxt = '0;
    end else if (mismatch && (err_cnt != '1)) begin
      err_nxt = err_cnt + CNT_W'(1);
    end
  end

  // Run bookkeeping: operand registers, counters, drain timer and pass flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a         <= '0;
      b         <= '0;
      num_vec_q <= '0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
      drain_cnt <= '0;
      pass      <= 1'b0;
    end else begin
      err_cnt <= err_nxt;
      if (accept) begin
        num_vec_q <= num_vec;
        vec_cnt   <= '0;
      end
      if (issue) begin
        a       <= lfsr_q[WIDTH-1:0];
        b       <= lfsr_q[LFSR_W-1:WIDTH];
        vec_cnt <= vec_cnt + CNT_W'(1);
      end
      if (state == RUN && state_nxt == DRAIN) begin
        drain_cnt <= 4'(LATENCY - 1);
      end else if (state == DRAIN && drain_cnt != 4'd0) begin
        drain_cnt <= drain_cnt - 4'd1;
      end
      // pass must already be valid in the DONE cycle, including the final check.
      if (state_nxt == DONE) begin
        pass <= (err_nxt == '0);
      end else if (accept) begin
        pass <= 1'b0;
      end
    end
  end

  // Expected-sum delay line, aligned to when the adder presents c.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_exp[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= issue;
      pipe_exp[0] <= exp_new;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
      end
    end
  end

endmodule

// File: doc/adder_stim_chk.md
Name: adder_stim_chk

Overview:
- Synthesizable initiator for the adder operand/result interface: drives a/b with pseudo-random operands and checks the returned c against a locally computed sum.
- Used for on-silicon/FPGA self-test of the adder block and as an RTL stimulus source in regression.
- Sits on the opposite end of the adder's interface: its outputs a/b connect to the adder inputs, and the adder output c feeds back into it.

Parameters:
- WIDTH, 8, operand width; c is WIDTH+1 bits.
- LATENCY, 1, adder clock cycles from a/b sampled to c valid (range 1..8).
- CNT_W, 16, width of vector and error counters.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a run when IDLE.
- num_vec  input  CNT_W  number of vectors to issue, sampled on start.
- seed  input  2*WIDTH  LFSR seed, sampled on start.
- a  output  WIDTH  operand A to adder.
- b  output  WIDTH  operand B to adder.
- c  input  WIDTH+1  adder result.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  high when the last run finished with err_cnt==0; held until next accepted start.
- err_cnt  output  CNT_W  mismatch count, saturating at all-ones.
- vec_cnt  output  CNT_W  vectors issued in current/last run.

Behaviour:
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, vec_cnt=0, FSM=IDLE, delay line valids=0.
- FSM states and transitions:
  - IDLE -> RUN on start with num_vec!=0.
  - IDLE -> DONE on start with num_vec==0.
  - RUN -> DRAIN when vec_cnt reaches num_vec.
  - DRAIN -> DONE after LATENCY cycles.
  - DONE -> IDLE unconditionally (one cycle).
- Accepted start:
  - Clears err_cnt, vec_cnt and pass.
  - Loads the LFSR with seed; seed==0 is replaced by constant 1 (an all-zero LFSR locks up).
- start is ignored outside IDLE; no effect on the run in progress.
- LFSR: 2*WIDTH-bit Galois, maximal-length taps for the configured width held as a package constant. Advances once per issued vector.
- Operand issue in RUN: each cycle a=LFSR[WIDTH-1:0], b=LFSR[2*WIDTH-1:WIDTH], both registered. One vector per cycle, vec_cnt+1 per vector.
- Outside RUN, a and b hold their last values.
- Expected pipeline:
  - Each issued vector pushes {valid=1, exp=a+b as WIDTH+1 bits, zero-extended} into a LATENCY-deep shift register; non-issue cycles push valid=0.
  - The output stage aligns with the cycle the adder presents c.
- Check: when the pipeline output valid=1 and c!=exp, err_cnt increments, saturating at 2^CNT_W-1.
- Carry: exp includes bit WIDTH; carry-out errors count as mismatches.
- DONE cycle: done=1 and pass=(err_cnt==0), where err_cnt includes the final check, which completes in the last DRAIN cycle. err_cnt and vec_cnt hold after DONE.
- Reset mid-run: immediate return to IDLE with reset values; in-flight expectations are discarded.
- Total run length from start to done pulse: num_vec + LATENCY + 1 cycles (num_vec>0).

Decomposition:
- Package adder_stim_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - LFSR tap constants per width;
  - default WIDTH/LATENCY.
- One sub-module, stim_lfsr (seedable Galois LFSR with load/advance enables), instantiated once.
- The expected-value delay line stays inline.

Test Plan:
- Reset released, start with num_vec=4, seed=16'h0001, ideal adder LATENCY=1 -> busy for 5 cycles, done pulse 6 cycles after start, pass=1, err_cnt=0, vec_cnt=4.
- Adder model with c[0] forced to 0, num_vec=100 -> err_cnt equals the count of issued vectors with an odd sum, pass=0.
- Seed=0, num_vec=3 -> operand sequence identical to seed=1.
- Operands 8'hFF+8'hFF forced via a seed producing that pair -> expected 9'h1FE checked; carry-stripping adder model gives err_cnt=1.
- num_vec=0 -> done pulse on the cycle after start, busy never high, pass=1.
- Reset asserted mid-RUN at vec_cnt=10 -> all outputs to reset values the same cycle; a new start afterwards runs cleanly; a second start during RUN is ignored.
